// File: rtl/fhe_op_sequencer_pkg.sv
// Shared types for the FHE op sequencer: op word, op modes, FSM states.
package fhe_op_sequencer_pkg;

    typedef enum logic [2:0] {
        NO_OP        = 3'd0,
        OP_CT_CT_ADD = 3'd1,
        OP_CT_PT_ADD = 3'd2,
        OP_CT_PT_MUL = 3'd3,
        OP_CT_CT_MUL = 3'd4
    } op_mode_t;

    typedef struct packed {
        op_mode_t   mode;
        logic [7:0] in0;
        logic [7:0] in1;
        logic [7:0] in2;
        logic [7:0] in3;
        logic [7:0] out0;
        logic [7:0] out1;
    } operation;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SETTLE
    } seq_state_t;

    function automatic logic is_mul_mode(op_mode_t m);
        return (m == OP_CT_PT_MUL) || (m == OP_CT_CT_MUL);
    endfunction

endpackage

// File: rtl/fhe_op_sequencer_if.sv
// Host, cpu, retire and status signals of the op sequencer.
interface fhe_op_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    import fhe_op_sequencer_pkg::*;

    logic             in_valid;
    operation         in_op;
    logic             in_ready;
    operation         cpu_op;
    logic             cpu_done;
    logic             retire_valid;
    op_mode_t         retire_mode;
    logic [CNT_W-1:0] retire_cycles;
    logic             retire_timeout;
    logic             busy;
    logic             err;
    logic             clear_err;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] retired_cnt;

    modport slave (
        input  in_valid, in_op, cpu_done, clear_err,
        output in_ready, cpu_op, retire_valid, retire_mode, retire_cycles,
               retire_timeout, busy, err, issued_cnt, retired_cnt
    );

    modport master (
        output in_valid, in_op, cpu_done, clear_err,
        input  in_ready, cpu_op, retire_valid, retire_mode, retire_cycles,
               retire_timeout, busy, err, issued_cnt, retired_cnt
    );

endinterface

// File: rtl/fhe_op_sequencer_op_fifo.sv
// Power-of-two FIFO of operation words with full/empty flags.
module op_fifo
    import fhe_op_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  operation wr_data_i,
    input  logic     pop_i,
    output operation rd_data_o,
    output logic     full_o,
    output logic     empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    operation         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign rd_data_o = mem_q[rd_ptr_q];
    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_push   = push_i & (~full_o | pop_i);
    assign do_pop    = pop_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/fhe_op_sequencer.sv
// Queues FHE ops and issues them one at a time to the cpu with a
// per-class timeout watchdog, retire records and status counters.
module fhe_op_sequencer
    import fhe_op_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned ADD_TIMEOUT   = 16,
    parameter int unsigned MUL_TIMEOUT   = 500,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input logic               clk,
    input logic               reset_n,
    fhe_op_sequencer_if.slave bus
);
    localparam int unsigned      SET_W   = $clog2(SETTLE_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ADD_LIM = (64'(ADD_TIMEOUT) > 64'(CNT_MAX)) ? CNT_MAX : CNT_W'(ADD_TIMEOUT);
    localparam logic [CNT_W-1:0] MUL_LIM = (64'(MUL_TIMEOUT) > 64'(CNT_MAX)) ? CNT_MAX : CNT_W'(MUL_TIMEOUT);

    seq_state_t       state_q, state_d;
    operation         cpu_op_q, cpu_op_d;
    op_mode_t         cur_mode_q, cur_mode_d;
    logic [CNT_W-1:0] wait_q, wait_d, wait_inc, wait_lim;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] issued_q, issued_d, retired_q, retired_d;
    logic             ret_valid_q, ret_valid_d;
    op_mode_t         ret_mode_q, ret_mode_d;
    logic [CNT_W-1:0] ret_cycles_q, ret_cycles_d;
    logic             ret_to_q, ret_to_d;

    logic     push, pop, issue, can_issue;
    logic     fifo_full, fifo_empty, in_ready;
    operation head;

    assign in_ready = ~fifo_full;
    assign push     = bus.in_valid & in_ready & (bus.in_op.mode != NO_OP);

    op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push_i    (push),
        .wr_data_i (bus.in_op),
        .pop_i     (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        cpu_op_d     = cpu_op_q;
        cur_mode_d   = cur_mode_q;
        wait_d       = wait_q;
        settle_d     = settle_q;
        err_d        = err_q & ~bus.clear_err;
        issued_d     = issued_q;
        retired_d    = retired_q;
        ret_valid_d  = 1'b0;
        ret_mode_d   = ret_mode_q;
        ret_cycles_d = ret_cycles_q;
        ret_to_d     = ret_to_q;
        pop          = 1'b0;
        issue        = 1'b0;
        wait_inc     = (wait_q == CNT_MAX) ? CNT_MAX : wait_q + CNT_W'(1);
        wait_lim     = is_mul_mode(cur_mode_q) ? MUL_LIM : ADD_LIM;
        can_issue    = ~fifo_empty & ~err_q;

        case (state_q)
            ST_IDLE: issue = can_issue;
            ST_ISSUE: begin
                cpu_op_d.mode = NO_OP;
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                wait_d = wait_inc;
                // done wins over a timeout reached in the same cycle
                if (bus.cpu_done || (wait_inc >= wait_lim)) begin
                    ret_valid_d  = 1'b1;
                    ret_mode_d   = cur_mode_q;
                    ret_cycles_d = wait_inc;
                    ret_to_d     = ~bus.cpu_done;
                    retired_d    = retired_q + CNT_W'(1);
                    if (!bus.cpu_done) err_d = 1'b1;
                    settle_d     = SET_W'(SETTLE_CYCLES);
                    state_d      = (SETTLE_CYCLES == 0) ? ST_IDLE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Last settle cycle doubles as the idle arbitration slot.
                if (settle_q > SET_W'(1)) settle_d = settle_q - SET_W'(1);
                else if (can_issue)       issue    = 1'b1;
                else                      state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            pop        = 1'b1;
            cpu_op_d   = head;
            cur_mode_d = head.mode;
            issued_d   = issued_q + CNT_W'(1);
            wait_d     = '0;
            state_d    = ST_ISSUE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cpu_op_q     <= '0;
            cur_mode_q   <= NO_OP;
            wait_q       <= '0;
            settle_q     <= '0;
            err_q        <= 1'b0;
            issued_q     <= '0;
            retired_q    <= '0;
            ret_valid_q  <= 1'b0;
            ret_mode_q   <= NO_OP;
            ret_cycles_q <= '0;
            ret_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_op_q     <= cpu_op_d;
            cur_mode_q   <= cur_mode_d;
            wait_q       <= wait_d;
            settle_q     <= settle_d;
            err_q        <= err_d;
            issued_q     <= issued_d;
            retired_q    <= retired_d;
            ret_valid_q  <= ret_valid_d;
            ret_mode_q   <= ret_mode_d;
            ret_cycles_q <= ret_cycles_d;
            ret_to_q     <= ret_to_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.cpu_op         = cpu_op_q;
    assign bus.retire_valid   = ret_valid_q;
    assign bus.retire_mode    = ret_mode_q;
    assign bus.retire_cycles  = ret_cycles_q;
    assign bus.retire_timeout = ret_to_q;
    assign bus.busy           = ~fifo_empty | (state_q != ST_IDLE);
    assign bus.err            = err_q;
    assign bus.issued_cnt     = issued_q;
    assign bus.retired_cnt    = retired_q;

endmodule

// File: tb/tb_fhe_op_sequencer.sv
// Scoreboard bench for fhe_op_sequencer: expected issues/retires are queued
// at accept time and popped by monitors; a small cpu model answers issues.
module tb_fhe_op_sequencer;
    import fhe_op_sequencer_pkg::*;

    localparam int DEPTH  = 8;
    localparam int ADD_TO = 16;
    localparam int MUL_TO = 500;
    localparam int SETTLE = 2;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fhe_op_sequencer_if #(.CNT_W(CNT_W)) bus ();

    fhe_op_sequencer #(
        .DEPTH(DEPTH), .ADD_TIMEOUT(ADD_TO), .MUL_TIMEOUT(MUL_TO),
        .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        op_mode_t mode;
        int       cycles;
        bit       timeout;
    } ret_rec_t;

    operation exp_issue_q[$];
    ret_rec_t exp_ret_q[$];
    int       lat_q[$];
    int       total = 0;
    int       bad = 0;
    int       cyc = 0;
    int       last_done_cyc = -100;
    bit       check_gap = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic operation mk(op_mode_t m, int b);
        operation o;
        o.mode = m;
        o.in0  = 8'(b);
        o.in1  = 8'(b + 1);
        o.in2  = 8'(b + 2);
        o.in3  = 8'(b + 3);
        o.out0 = 8'(b + 5);
        o.out1 = 8'(b + 6);
        return o;
    endfunction

    // lat = cycles from issue to done; 0 means the cpu never answers
    task automatic note_accept(operation o, int lat);
        ret_rec_t r;
        if (o.mode == NO_OP) return;
        exp_issue_q.push_back(o);
        lat_q.push_back(lat);
        r.mode = o.mode;
        if (lat == 0) begin
            r.cycles  = (o.mode == OP_CT_PT_MUL || o.mode == OP_CT_CT_MUL) ? MUL_TO : ADD_TO;
            r.timeout = 1'b1;
        end else begin
            r.cycles  = lat;
            r.timeout = 1'b0;
        end
        exp_ret_q.push_back(r);
    endtask

    task automatic enqueue(operation o, int lat);
        int waited = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = o;
        while (!bus.in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("enqueue_wait", bus.in_ready, 1);
            bus.in_valid = 1'b0;
            return;
        end
        note_accept(o, lat);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_retired(int n, int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.retired_cnt != CNT_W'(n) && k < budget);
        if (bus.retired_cnt != CNT_W'(n)) check("wait_retired", bus.retired_cnt, n);
    endtask

    task automatic wait_err(int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.err && k < budget);
        check("err_set_on_timeout", bus.err, 1);
    endtask

    task automatic pulse_clear_err();
        @(negedge clk);
        bus.clear_err = 1'b1;
        @(negedge clk);
        bus.clear_err = 1'b0;
    endtask

    task automatic chk_reset_vals(string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_retire_valid"}, bus.retire_valid, 0);
        check({tag, "_retire_timeout"}, bus.retire_timeout, 0);
        check({tag, "_retire_cycles"}, bus.retire_cycles, 0);
        check({tag, "_cpu_op"}, 64'(bus.cpu_op), 0);
        check({tag, "_issued_cnt"}, bus.issued_cnt, 0);
        check({tag, "_retired_cnt"}, bus.retired_cnt, 0);
    endtask

    initial begin : cpu_model
        int cd;
        bit active;
        int l;
        cd = 0;
        active = 1'b0;
        bus.cpu_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.cpu_done = 1'b0;
            if (!reset_n) begin
                active = 1'b0;
                continue;
            end
            if (active) begin
                cd--;
                if (cd == 0) begin
                    bus.cpu_done  = 1'b1;
                    active        = 1'b0;
                    last_done_cyc = cyc;
                end
            end
            if (bus.cpu_op.mode != NO_OP && lat_q.size() > 0) begin
                l = lat_q.pop_front();
                if (l > 0) begin
                    active = 1'b1;
                    cd     = l;
                end
            end
        end
    end

    initial begin : issue_mon
        op_mode_t prev_mode;
        operation e;
        prev_mode = NO_OP;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_mode = NO_OP;
                continue;
            end
            if (prev_mode != NO_OP) check("issue_then_noop", bus.cpu_op.mode, NO_OP);
            if (bus.cpu_op.mode != NO_OP && prev_mode == NO_OP) begin
                check("issue_expected", exp_issue_q.size() > 0, 1);
                if (exp_issue_q.size() > 0) begin
                    e = exp_issue_q.pop_front();
                    check("issue_op", 64'(bus.cpu_op), 64'(e));
                end
                if (check_gap) begin
                    check("settle_gap", cyc - last_done_cyc - 1, SETTLE);
                    check_gap = 1'b0;
                end
            end
            prev_mode = bus.cpu_op.mode;
        end
    end

    initial begin : retire_mon
        int n_ret;
        bit prev_v;
        ret_rec_t r;
        n_ret  = 0;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                n_ret  = 0;
                prev_v = 1'b0;
                continue;
            end
            if (bus.retire_valid) begin
                check("retire_pulse_width", prev_v, 0);
                check("retire_expected", exp_ret_q.size() > 0, 1);
                if (exp_ret_q.size() > 0) begin
                    r = exp_ret_q.pop_front();
                    check("retire_mode", bus.retire_mode, r.mode);
                    check("retire_cycles", bus.retire_cycles, r.cycles);
                    check("retire_timeout", bus.retire_timeout, r.timeout);
                end
                n_ret++;
                check("retired_cnt", bus.retired_cnt, n_ret);
            end
            prev_v = bus.retire_valid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin : stim
        op_mode_t fill_modes [9];
        fill_modes = '{OP_CT_CT_ADD, OP_CT_PT_ADD, OP_CT_PT_MUL, OP_CT_CT_MUL, OP_CT_CT_ADD,
                       OP_CT_PT_MUL, OP_CT_PT_ADD, OP_CT_CT_MUL, OP_CT_CT_ADD};
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.clear_err = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset_n = 1'b1;

        // single add answered 3 cycles after issue
        enqueue(mk(OP_CT_CT_ADD, 0), 3);
        wait_retired(1, 50);
        check("t1_issued_cnt", bus.issued_cnt, 1);
        check("t1_err", bus.err, 0);

        // done on the very cycle the add timeout is reached
        enqueue(mk(OP_CT_PT_ADD, 16), ADD_TO);
        wait_retired(2, 60);
        check("t2_err_after_tie", bus.err, 0);

        // two queued adds: settle window between them
        enqueue(mk(OP_CT_CT_ADD, 32), 2);
        enqueue(mk(OP_CT_PT_ADD, 40), 2);
        wait_retired(3, 40);
        check_gap = 1'b1;
        wait_retired(4, 40);
        check("t3_gap_seen", check_gap, 0);

        // mul that never completes, then a queued add held back by err
        enqueue(mk(OP_CT_CT_MUL, 64), 0);
        enqueue(mk(OP_CT_CT_ADD, 72), 4);
        wait_err(700);
        repeat (20) @(negedge clk);
        check("t4_no_issue_while_err", bus.issued_cnt, 5);
        check("t4_retired_cnt", bus.retired_cnt, 5);
        check("t4_busy_with_queue", bus.busy, 1);
        pulse_clear_err();
        wait_retired(6, 40);
        check("t4_err_cleared", bus.err, 0);
        check("t4_issued_after_clear", bus.issued_cnt, 6);

        // add timeout sets err, then fill the FIFO while issue is blocked
        enqueue(mk(OP_CT_PT_ADD, 80), 0);
        wait_err(40);
        check("t5_retired_cnt", bus.retired_cnt, 7);
        for (int i = 0; i < DEPTH; i++) enqueue(mk(fill_modes[i], 100 + 8 * i), i + 1);
        @(negedge clk);
        check("t5_full_in_ready", bus.in_ready, 0);
        check("t5_busy_full", bus.busy, 1);
        bus.in_valid = 1'b1;
        bus.in_op    = mk(fill_modes[DEPTH], 200);
        repeat (3) @(negedge clk);
        check("t5_held_in_ready", bus.in_ready, 0);
        check("t5_no_issue_while_err", bus.issued_cnt, 7);
        pulse_clear_err();
        enqueue(mk(fill_modes[DEPTH], 200), DEPTH + 1);
        wait_retired(16, 400);
        check("t5_issued_cnt", bus.issued_cnt, 16);
        check("t5_err", bus.err, 0);
        check("t5_scoreboard_drained", exp_ret_q.size(), 0);

        // reset while a mul is in WAIT with three ops behind it
        enqueue(mk(OP_CT_PT_MUL, 120), 0);
        enqueue(mk(OP_CT_CT_ADD, 130), 2);
        enqueue(mk(OP_CT_PT_ADD, 140), 2);
        enqueue(mk(OP_CT_CT_MUL, 150), 2);
        repeat (10) @(negedge clk);
        check("t6_mul_in_flight", bus.issued_cnt, 17);
        reset_n = 1'b0;
        exp_issue_q.delete();
        exp_ret_q.delete();
        lat_q.delete();
        #1;
        chk_reset_vals("midreset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_no_stale_issue", bus.issued_cnt, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_in_ready", bus.in_ready, 1);
        check("t6_cpu_op_mode", bus.cpu_op.mode, NO_OP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
